axi_lite_arbiter: RTL

Parametrised N-master to 1-slave AXI4-Lite arbiter that lets several core-side AXI-Lite masters (e.g. fetch and LSU) share a single memory or peripheral slave. Read and write channels are arbitrated independently, each with its own round-robin grant held from address acceptance until the response handshake. Sits between the core's master ports and a shared slave such as a unified SRAM.

---
 rtl/axi_lite_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter with independent round-robin read and write channels.
// Each channel holds its grant from address acceptance until the response handshake.
module axi_lite_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_araddr,
  input  logic [NUM_MASTERS-1:0]          m_arvalid,
  output logic [NUM_MASTERS-1:0]          m_arready,
  output logic [NUM_MASTERS*DATA_W-1:0]   m_rdata,
  output logic [NUM_MASTERS*2-1:0]        m_rresp,
  output logic [NUM_MASTERS-1:0]          m_rvalid,
  input  logic [NUM_MASTERS-1:0]          m_rready,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_awaddr,
  input  logic [NUM_MASTERS-1:0]          m_awvalid,
  output logic [NUM_MASTERS-1:0]          m_awready,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]          m_wvalid,
  output logic [NUM_MASTERS-1:0]          m_wready,
  output logic [NUM_MASTERS*2-1:0]        m_bresp,
  output logic [NUM_MASTERS-1:0]          m_bvalid,
  input  logic [NUM_MASTERS-1:0]          m_bready,
  output logic [ADDR_W-1:0]               s_araddr,
  output logic                            s_arvalid,
  input  logic                            s_arready,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic [1:0]                      s_rresp,
  input  logic                            s_rvalid,
  output logic                            s_rready,
  output logic [ADDR_W-1:0]               s_awaddr,
  output logic                            s_awvalid,
  input  logic                            s_awready,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  output logic                            s_wvalid,
  input  logic                            s_wready,
  input  logic [1:0]                      s_bresp,
  input  logic                            s_bvalid,
  output logic                            s_bready
);
  localparam int STRB_W = DATA_W/8;
  localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA}   rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_RESP} wr_state_t;

  rd_state_t        rd_state, rd_nxt;
  wr_state_t        wr_state, wr_nxt;
  logic [IDX_W-1:0] rd_gnt, rd_ptr, wr_gnt, wr_ptr;
  logic             aw_done, w_done, aw_hs, w_hs;
  logic [NUM_MASTERS-1:0] wr_req;

  // First requester at or above ptr, wrapping; the just-served master sits last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (int'(ptr) + k) % NUM_MASTERS;
      if (!found && req[idx]) begin
        rr_pick = IDX_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
    ptr_after = (int'(g) == NUM_MASTERS-1) ? '0 : g + 1'b1;
  endfunction

  assign m_rdata = {NUM_MASTERS{s_rdata}};
  assign m_rresp = {NUM_MASTERS{s_rresp}};
  assign m_bresp = {NUM_MASTERS{s_bresp}};
  assign wr_req  = m_awvalid | m_wvalid;

  // Read channel
  always_comb begin
    rd_nxt    = rd_state;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    case (rd_state)
      R_IDLE: if (|m_arvalid) rd_nxt = R_ADDR;
      R_ADDR: begin
        s_araddr          = m_araddr[int'(rd_gnt)*ADDR_W +: ADDR_W];
        s_arvalid         = m_arvalid[rd_gnt];
        m_arready[rd_gnt] = s_arready;
        if (m_arvalid[rd_gnt] && s_arready) rd_nxt = R_DATA;
      end
      R_DATA: begin
        m_rvalid[rd_gnt] = s_rvalid;
        s_rready         = m_rready[rd_gnt];
        if (s_rvalid && m_rready[rd_gnt]) rd_nxt = R_IDLE;
      end
      default: rd_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      rd_gnt   <= '0;
      rd_ptr   <= '0;
    end else begin
      rd_state <= rd_nxt;
      if (rd_state == R_IDLE && |m_arvalid) rd_gnt <= rr_pick(m_arvalid, rd_ptr);
      if (rd_state == R_DATA && rd_nxt == R_IDLE) rd_ptr <= ptr_after(rd_gnt);
    end
  end

  // Write channel: AW and W complete in either order, each forwarded only once
  always_comb begin
    wr_nxt    = wr_state;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (wr_state)
      W_IDLE: if (|wr_req) wr_nxt = W_ACTIVE;
      W_ACTIVE: begin
        s_awaddr = m_awaddr[int'(wr_gnt)*ADDR_W +: ADDR_W];
        s_wdata  = m_wdata[int'(wr_gnt)*DATA_W +: DATA_W];
        s_wstrb  = m_wstrb[int'(wr_gnt)*STRB_W +: STRB_W];
        if (!aw_done) begin
          s_awvalid         = m_awvalid[wr_gnt];
          m_awready[wr_gnt] = s_awready;
          aw_hs             = m_awvalid[wr_gnt] & s_awready;
        end
        if (!w_done) begin
          s_wvalid         = m_wvalid[wr_gnt];
          m_wready[wr_gnt] = s_wready;
          w_hs             = m_wvalid[wr_gnt] & s_wready;
        end
        if ((aw_done || aw_hs) && (w_done || w_hs)) wr_nxt = W_RESP;
      end
      W_RESP: begin
        m_bvalid[wr_gnt] = s_bvalid;
        s_bready         = m_bready[wr_gnt];
        if (s_bvalid && m_bready[wr_gnt]) wr_nxt = W_IDLE;
      end
      default: wr_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      wr_gnt   <= '0;
      wr_ptr   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_nxt;
      case (wr_state)
        W_IDLE: if (|wr_req) begin
          wr_gnt  <= rr_pick(wr_req, wr_ptr);
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        W_ACTIVE: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        W_RESP: if (wr_nxt == W_IDLE) wr_ptr <= ptr_after(wr_gnt);
        default: ;
      endcase
    end
  end
endmodule
